// File: rtl/sram_ctrl_pkg.sv
// Shared types for the Wishbone-to-asynchronous-SRAM controller:
// the access-sequence states and the bundle of SRAM pin controls.
package sram_ctrl_pkg;

  localparam int SRAM_BE_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  typedef struct packed {
    logic                     ce_n;
    logic                     oe_n;
    logic                     we_n;
    logic [SRAM_BE_WIDTH-1:0] be_n;
    logic                     data_t;
  } sram_ctrl_t;

  // Chip deselected, all lanes off, pad released.
  localparam sram_ctrl_t SRAM_CTRL_IDLE = '{
    ce_n:   1'b1,
    oe_n:   1'b1,
    we_n:   1'b1,
    be_n:   {SRAM_BE_WIDTH{1'b1}},
    data_t: 1'b1
  };

endpackage

// File: rtl/sram_controller.sv
// Wishbone classic slave that turns single read/write cycles into timed
// accesses to one external asynchronous 32-bit SRAM; every output is registered.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 32,
  parameter int SRAM_ADDR_WIDTH    = 20,
  parameter int SRAM_DATA_WIDTH    = 32,
  parameter int READ_WAIT_CYCLES   = 2,
  parameter int WRITE_PULSE_CYCLES = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  output logic                         wb_ack_o,
  input  logic [ADDR_WIDTH-1:0]        wb_adr_i,
  input  logic [DATA_WIDTH-1:0]        wb_dat_i,
  output logic [DATA_WIDTH-1:0]        wb_dat_o,
  input  logic [DATA_WIDTH/8-1:0]      wb_sel_i,
  input  logic                         wb_we_i,
  output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr_o,
  input  logic [SRAM_DATA_WIDTH-1:0]   sram_data_i,
  output logic [SRAM_DATA_WIDTH-1:0]   sram_data_o,
  output logic                         sram_data_t_o,
  output logic                         sram_ce_n_o,
  output logic                         sram_oe_n_o,
  output logic                         sram_we_n_o,
  output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n_o
);

  localparam int WAIT_MAX = (READ_WAIT_CYCLES > WRITE_PULSE_CYCLES) ?
                            READ_WAIT_CYCLES : WRITE_PULSE_CYCLES;
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_PULSE_CYCLES - 1);

  state_t           state;
  sram_ctrl_t       ctrl;
  logic [CNT_W-1:0] wait_cnt;

  // Byte offset and bits above the SRAM size are dropped, so accesses wrap.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2], wb_adr_i[1:0]};

  assign sram_ce_n_o   = ctrl.ce_n;
  assign sram_oe_n_o   = ctrl.oe_n;
  assign sram_we_n_o   = ctrl.we_n;
  assign sram_be_n_o   = ctrl.be_n;
  assign sram_data_t_o = ctrl.data_t;

  // Controls are written on entry to each state so the pins change together
  // with the state register; reads never drive the pad, so OE and a driven
  // pad cannot overlap.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      ctrl        <= SRAM_CTRL_IDLE;
      wait_cnt    <= '0;
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
      sram_addr_o <= '0;
      sram_data_o <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            sram_addr_o <= wb_adr_i[SRAM_ADDR_WIDTH+1:2];
            sram_data_o <= wb_dat_i;
            wait_cnt    <= '0;
            if (wb_we_i) begin
              state <= WR_SETUP;
              ctrl  <= '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1,
                         be_n: ~wb_sel_i, data_t: 1'b0};
            end else begin
              state <= RD;
              ctrl  <= '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1,
                         be_n: ~wb_sel_i, data_t: 1'b1};
            end
          end
        end
        RD: begin
          if (wait_cnt == RD_LAST) begin
            wb_dat_o <= sram_data_i;
            wb_ack_o <= wb_cyc_i;
            ctrl     <= SRAM_CTRL_IDLE;
            wait_cnt <= '0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        WR_SETUP: begin
          ctrl.we_n <= 1'b0;
          wait_cnt  <= '0;
          state     <= WR_PULSE;
        end
        WR_PULSE: begin
          if (wait_cnt == WR_LAST) begin
            ctrl.we_n <= 1'b1;
            wait_cnt  <= '0;
            state     <= WR_HOLD;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        WR_HOLD: begin
          // An aborted master still gets a complete write, just no ack.
          wb_ack_o <= wb_cyc_i;
          ctrl     <= SRAM_CTRL_IDLE;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          ctrl  <= SRAM_CTRL_IDLE;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
